aes_inv_round_ctrl: RTL and testbench
=====================================

# aes_inv_round_ctrl

Iterative AES inverse-cipher round sequencer. It accepts one 128-bit ciphertext state over a valid/ready handshake and fetches round keys from an external asynchronous-read round-key file. It applies one full inverse round per clock through instantiated `inv_shift_rows`, `inv_sub_bytes` and `inv_mix_columns` datapath blocks, then returns the plaintext state over a second valid/ready handshake. It sits between the decryption front end and the key-expansion/round-key store.

## Interface
- `NR`, default 10: number of rounds. Legal values are 10, 12 and 14; any other value is a configuration error.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: ciphertext state present.
- `in_ready` out 1: block can accept a state.
- `in_data` in 128: ciphertext state, row-major.
- `out_valid` out 1: plaintext state present.
- `out_ready` in 1: consumer accepts the plaintext.
- `out_data` out 128: plaintext state, row-major.
- `key_idx` out 4: round-key index requested this cycle.
- `round_key` in 128: key at `key_idx`, combinational (same-cycle) read.
- `busy` out 1: high in ROUND, FINAL and DONE.

## Operation
- **State layout:** row r occupies bytes 4r..4r+3, and byte 0 is `[127:120]`. This is the same layout the team's `inv_shift_rows` uses. A FIPS-197 column-major vector maps its byte i to s(i%4, i/4).
- **FSM states:** IDLE, ROUND, FINAL, DONE. There is a 4-bit round counter `rnd` and a 128-bit state register `st`.
- **IDLE**
  - `in_ready`=1 and `key_idx`=NR.
  - On `in_valid`: `st` <= `in_data` ^ `round_key`, `rnd` <= NR-1, go to ROUND.
- **ROUND**
  - `key_idx`=`rnd`.
  - `st` <= InvMixColumns(InvSubBytes(InvShiftRows(`st`)) ^ `round_key`).
  - If `rnd`==1, go to FINAL; otherwise `rnd` <= `rnd`-1.
- **FINAL**
  - `key_idx`=0.
  - `st` <= InvSubBytes(InvShiftRows(`st`)) ^ `round_key`, then go to DONE.
- **DONE**
  - `out_valid`=1 and `out_data`=`st`.
  - On `out_ready`, go to IDLE.
- **Output rules:**
  - `out_data` is driven from `st` in every state. It is meaningful only while `out_valid`=1.
  - `in_ready` is low in all states other than IDLE. A new input is never accepted in the same cycle as an output handshake.
- **Reset:** `rst` takes priority over every transition, including mid-round. Reset values:
  - FSM=IDLE, `rnd`=0, `st`=0
  - `out_valid`=0, `in_ready`=1, `busy`=0, `key_idx`=NR, `out_data`=0.
- **`key_idx` timing:** `key_idx` is decoded only from the FSM state and `rnd`, never from inputs. It is stable from each clock edge onward, so the key file's combinational path has a full cycle.

## Timing
- The accept edge is cycle 0.
- States per block: NR-1 cycles in ROUND, then 1 cycle in FINAL.
- `out_valid` rises at cycle NR after the accept edge (cycle 10 for NR=10).
- With `out_ready` held high, DONE lasts 1 cycle, giving a minimum initiation interval of NR+2 cycles per block.
- **Backpressure:** while `out_valid`=1 and `out_ready`=0, `out_data` and `out_valid` hold unchanged indefinitely.
- **Input sampling:** `in_data` is sampled only on the accept edge. Changes to `in_valid` or `in_data` outside IDLE are ignored.
- **`round_key` sampling:** `round_key` is sampled on every edge in IDLE-accept, ROUND and FINAL. It is ignored in DONE.
- **Simultaneous `rst` and handshake:** reset wins. Nothing is accepted and no output handshake completes.

## Test plan
- **FIPS-197 C.1 (AES-128, NR=10):**
  - Stimulus: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a (transposed to row-major) with expanded key 000102…0f served by a model key file.
  - Required: `out_data` equals transposed 00112233445566778899aabbccddeeff, and `out_valid` rises exactly 10 cycles after accept.
  - Also check the `key_idx` sequence 10,9,…,1,0 on consecutive cycles starting at accept.
- **NR=14:**
  - Stimulus: FIPS-197 C.3 ciphertext 8ea2b7ca516745bfeafc49904b496089 with key 000102…1f.
  - Required: plaintext 00112233…eeff, latency 14 cycles.
- **Backpressure:** hold `out_ready`=0 for 20 cycles after `out_valid`. Required: `out_data` is stable, `in_ready`=0, and `in_valid` pulses are ignored. Release → IDLE on the next cycle with `in_ready`=1.
- **Back-to-back:** hold `in_valid` and `out_ready` high for 3 distinct ciphertexts. Required: accepts spaced exactly NR+2 cycles apart and correct plaintexts in order.
- **Mid-operation reset:** assert `rst` for 1 cycle in ROUND with `rnd`=5. Required: next cycle shows IDLE, `out_valid`=0, `out_data`=0, `key_idx`=NR. A following block then decrypts correctly.
- **Input stability:** toggle `in_data` randomly during ROUND. Required: the result matches the value sampled at accept.

Source files
------------

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES inverse-cipher round sequencer: one full inverse round per clock,
// round keys read combinationally from an external key file addressed by key_idx.

module inv_shift_rows (
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);
  // Row-major state: byte 4r+c lives at [127-8(4r+c) -: 8]; row r rotates right by r.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign state_o[8*(15-(4*r+c)) +: 8] = state_i[8*(15-(4*r+((c+4-r)%4))) +: 8];
    end
  end
endmodule

module inv_sub_bytes (
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Inverse affine map followed by the GF(2^8) inverse, computed as x^254.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] x;
    logic [7:0] pw;
    logic [7:0] inv;
    for (int i = 0; i < 8; i++) x[i] = b[(i+2)%8] ^ b[(i+5)%8] ^ b[(i+7)%8];
    x   = x ^ 8'h05;
    pw  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    return inv;
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign state_o[8*i +: 8] = inv_sbox(state_i[8*i +: 8]);
  end
endmodule

module inv_mix_columns (
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (genvar r = 0; r < 4; r++) begin : g_byte
      logic [7:0] a1, a2, a4, a8;
      assign a1    = state_i[8*(15-(4*r+c)) +: 8];
      assign a2    = xt(a1);
      assign a4    = xt(a2);
      assign a8    = xt(a4);
      assign m9[r] = a8 ^ a1;
      assign mb[r] = a8 ^ a2 ^ a1;
      assign md[r] = a8 ^ a4 ^ a1;
      assign me[r] = a8 ^ a4 ^ a2;
    end
    // Circulant matrix rows are rotations of {0e, 0b, 0d, 09}.
    for (genvar r = 0; r < 4; r++) begin : g_out
      assign state_o[8*(15-(4*r+c)) +: 8] =
        me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
    end
  end
endmodule

module aes_inv_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [3:0]   key_idx,
  input  logic [127:0] round_key,
  output logic         busy
);
  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_inv_round_ctrl: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] KeyLast  = 4'(NR);
  localparam logic [3:0] RndFirst = 4'(NR - 1);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_e;

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] st_q, st_d;
  logic [127:0] sr, sb, ark, mc;

  inv_shift_rows  u_isr (.state_i(st_q), .state_o(sr));
  inv_sub_bytes   u_isb (.state_i(sr),   .state_o(sb));
  assign ark = sb ^ round_key;
  inv_mix_columns u_imc (.state_i(ark),  .state_o(mc));

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rnd_q   <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
    end
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    st_d      = st_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    key_idx   = '0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        key_idx  = KeyLast;
        if (in_valid) begin
          st_d    = in_data ^ round_key;
          rnd_d   = RndFirst;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        key_idx = rnd_q;
        st_d    = mc;
        if (rnd_q == 4'd1) state_d = S_FINAL;
        else               rnd_d   = rnd_q - 4'd1;
      end
      S_FINAL: begin
        st_d    = ark;
        state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out_data = st_q;
endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Self-checking bench for aes_inv_round_ctrl: NR=10 and NR=14 instances against a
// table-driven FIPS-197 inverse-cipher model with its own key expansion.

module tb_aes_inv_round_ctrl;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         sel = 1'b0;
  logic [127:0] in_data = '0;

  logic         in_ready10, out_valid10, busy10, in_ready14, out_valid14, busy14;
  logic [127:0] out_data10, out_data14, round_key10, round_key14;
  logic [3:0]   key_idx10, key_idx14;

  logic         in_ready_m, out_valid_m, busy_m;
  logic [127:0] out_data_m;
  logic [3:0]   key_idx_m;

  logic [127:0] rk10 [16];
  logic [127:0] rk14 [16];
  logic [7:0]   sbox [256];
  logic [7:0]   isbox [256];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign round_key10 = rk10[key_idx10];
  assign round_key14 = rk14[key_idx14];
  assign in_ready_m  = sel ? in_ready14  : in_ready10;
  assign out_valid_m = sel ? out_valid14 : out_valid10;
  assign busy_m      = sel ? busy14      : busy10;
  assign out_data_m  = sel ? out_data14  : out_data10;
  assign key_idx_m   = sel ? key_idx14   : key_idx10;

  aes_inv_round_ctrl #(.NR(10)) dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(in_ready10),
    .in_data(in_data), .out_valid(out_valid10), .out_ready(out_ready),
    .out_data(out_data10), .key_idx(key_idx10), .round_key(round_key10), .busy(busy10)
  );

  aes_inv_round_ctrl #(.NR(14)) dut14 (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(in_ready14),
    .in_data(in_data), .out_valid(out_valid14), .out_ready(out_ready),
    .out_data(out_data14), .key_idx(key_idx14), .round_key(round_key14), .busy(busy14)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rotl8(input int x, input int s);
    return ((x << s) | (x >> (8 - s))) & 255;
  endfunction

  // Forward S-box from the multiplicative-generator walk; inverse by table inversion.
  task automatic build_sbox();
    int p = 1;
    int q = 1;
    int x;
    do begin
      p = (p ^ (p << 1) ^ (((p & 128) != 0) ? 27 : 0)) & 255;
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      q = q & 255;
      if ((q & 128) != 0) q = q ^ 9;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox[p] = 8'(x ^ 99);
    end while (p != 1);
    sbox[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
  endtask

  function automatic logic [7:0] gm(input int a, input int b);
    int p = 0;
    for (int i = 0; i < 8; i++) begin
      if ((b & 1) != 0) p = p ^ a;
      a = (a << 1) ^ (((a & 128) != 0) ? 283 : 0);
      b = b >> 1;
    end
    return 8'(p);
  endfunction

  // FIPS-197 key expansion; round key r stored row-major for the key file.
  task automatic expand(input logic which, input logic [255:0] key, input int nr);
    logic [7:0] w [60][4];
    logic [7:0] t [4];
    logic [7:0] t0;
    logic [7:0] rcon;
    logic [127:0] k;
    int nk;
    nk   = nr - 6;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++)
      for (int j = 0; j < 4; j++) w[i][j] = key[8*(31-(4*i+j)) +: 8];
    for (int i = nk; i < 4*(nr+1); i++) begin
      for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
      if (i % nk == 0) begin
        t0   = t[0];
        t[0] = sbox[t[1]] ^ rcon;
        t[1] = sbox[t[2]];
        t[2] = sbox[t[3]];
        t[3] = sbox[t0];
        rcon = gm(int'(rcon), 2);
      end else if (nk > 6 && i % nk == 4) begin
        for (int j = 0; j < 4; j++) t[j] = sbox[t[j]];
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-nk][j] ^ t[j];
    end
    for (int r = 0; r <= nr; r++) begin
      for (int row = 0; row < 4; row++)
        for (int c = 0; c < 4; c++) k[8*(15-(4*row+c)) +: 8] = w[4*r+c][row];
      if (which) rk14[r] = k;
      else       rk10[r] = k;
    end
  endtask

  function automatic logic [127:0] to_rm(input logic [127:0] v);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*(15-(4*(i%4)+i/4)) +: 8] = v[8*(15-i) +: 8];
    return o;
  endfunction

  // Textbook InvCipher on a 4x4 byte matrix.
  function automatic logic [127:0] ref_dec(input logic [127:0] ct, input logic which);
    int m [4][4] = '{'{14, 11, 13, 9}, '{9, 14, 11, 13}, '{13, 9, 14, 11}, '{11, 13, 9, 14}};
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [7:0] a [4];
    logic [127:0] k, res;
    int nr;
    nr = which ? 14 : 10;
    for (int rd = nr; rd >= 0; rd--) begin
      k = which ? rk14[rd] : rk10[rd];
      if (rd == nr) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) s[r][c] = ct[8*(15-(4*r+c)) +: 8];
      end else begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) t[r][(c+r)%4] = s[r][c];
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) s[r][c] = isbox[t[r][c]];
      end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r][c] = s[r][c] ^ k[8*(15-(4*r+c)) +: 8];
      if (rd != nr && rd != 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = s[r][c];
          for (int r = 0; r < 4; r++) begin
            s[r][c] = '0;
            for (int j = 0; j < 4; j++) s[r][c] = s[r][c] ^ gm(int'(a[j]), m[r][j]);
          end
        end
      end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) res[8*(15-(4*r+c)) +: 8] = s[r][c];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_block(input logic [127:0] ct, input string tag, input bit key_chk,
                           input int hold, input bit use_kat, input logic [127:0] kat);
    logic [127:0] exp;
    int nr, lat;
    nr  = sel ? 14 : 10;
    exp = use_kat ? kat : ref_dec(ct, sel);
    in_data   = ct;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    check({tag, "_in_ready"}, 128'(in_ready_m), 128'd1);
    if (key_chk) check({tag, "_key_acc"}, 128'(key_idx_m), 128'(nr));
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid_m && lat < 64) begin
      if (key_chk) check($sformatf("%s_key%0d", tag, lat), 128'(key_idx_m), 128'(nr-1-lat));
      in_data  = rnd128();
      in_valid = 1'($urandom_range(0, 1));
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 128'(lat), 128'(nr));
    check({tag, "_data"}, out_data_m, exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      tick();
      check({tag, "_hold_data"}, out_data_m, exp);
      check({tag, "_hold_valid"}, 128'(out_valid_m), 128'd1);
      check({tag, "_hold_in_ready"}, 128'(in_ready_m), 128'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check({tag, "_idle_in_ready"}, 128'(in_ready_m), 128'd1);
    check({tag, "_idle_valid"}, 128'(out_valid_m), 128'd0);
  endtask

  task automatic back_to_back(input string tag);
    logic [127:0] cts [3];
    logic [127:0] expq [$];
    int acc_cyc [3] = '{0, 0, 0};
    int idx = 0;
    int outs = 0;
    int cyc = 0;
    int nr;
    bit acc;
    nr = sel ? 14 : 10;
    for (int i = 0; i < 3; i++) cts[i] = rnd128();
    in_data   = cts[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (outs < 3 && cyc < 200) begin
      acc = in_valid && in_ready_m;
      if (out_valid_m) begin
        if (expq.size() > 0) check($sformatf("%s_data%0d", tag, outs), out_data_m, expq.pop_front());
        else check($sformatf("%s_unexpected_out%0d", tag, outs), 128'(out_valid_m), 128'd0);
        outs++;
      end
      tick();
      cyc++;
      if (acc && idx < 3) begin
        acc_cyc[idx] = cyc;
        expq.push_back(ref_dec(cts[idx], sel));
        idx++;
        if (idx < 3) in_data = cts[idx];
        else         in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check({tag, "_outputs"}, 128'(outs), 128'd3);
    check({tag, "_gap01"}, 128'(acc_cyc[1] - acc_cyc[0]), 128'(nr + 2));
    check({tag, "_gap12"}, 128'(acc_cyc[2] - acc_cyc[1]), 128'(nr + 2));
  endtask

  initial begin
    int lat;
    build_sbox();
    for (int i = 0; i < 16; i++) begin
      rk10[i] = '0;
      rk14[i] = '0;
    end
    expand(1'b0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 10);
    expand(1'b1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 14);

    rst = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", 128'(in_ready_m), 128'd1);
    check("rst_out_valid", 128'(out_valid_m), 128'd0);
    check("rst_busy", 128'(busy_m), 128'd0);
    check("rst_key_idx", 128'(key_idx_m), 128'd10);
    check("rst_key_idx14", 128'(key_idx14), 128'd14);
    check("rst_out_data", out_data_m, 128'd0);
    rst = 1'b0;
    tick();

    // NR=10: FIPS-197 C.1, random blocks, backpressure, back-to-back.
    run_block(to_rm(128'h69c4e0d86a7b0430d8cdb78070b4c55a), "c1", 1'b1, 0, 1'b1,
              to_rm(128'h00112233445566778899aabbccddeeff));
    for (int i = 0; i < 3; i++) run_block(rnd128(), $sformatf("r10_%0d", i), 1'b0, 0, 1'b0, '0);
    run_block(rnd128(), "bp", 1'b0, 20, 1'b0, '0);
    back_to_back("b2b10");

    // Reset mid-round at rnd=5, then a normal block.
    in_data  = rnd128();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (key_idx_m != 4'd5 && lat < 64) begin
      tick();
      lat++;
    end
    check("mr_busy_before", 128'(busy_m), 128'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_in_ready", 128'(in_ready_m), 128'd1);
    check("mr_out_valid", 128'(out_valid_m), 128'd0);
    check("mr_out_data", out_data_m, 128'd0);
    check("mr_key_idx", 128'(key_idx_m), 128'd10);
    run_block(rnd128(), "mr_after", 1'b1, 0, 1'b0, '0);

    // Reset coinciding with an output handshake and a new input.
    in_data   = rnd128();
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid_m && lat < 64) begin
      tick();
      lat++;
    end
    check("rh_reached_done", 128'(out_valid_m), 128'd1);
    rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    tick();
    check("rh_out_valid", 128'(out_valid_m), 128'd0);
    check("rh_out_data", out_data_m, 128'd0);
    tick();
    check("rh_no_accept_busy", 128'(busy_m), 128'd0);
    check("rh_no_accept_key", 128'(key_idx_m), 128'd10);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();

    // NR=10 with a fresh random key.
    expand(1'b0, {rnd128(), 128'h0}, 10);
    for (int i = 0; i < 2; i++) run_block(rnd128(), $sformatf("rk10_%0d", i), 1'b0, 0, 1'b0, '0);

    // NR=14: FIPS-197 C.3, random blocks, back-to-back.
    sel = 1'b1;
    tick();
    run_block(to_rm(128'h8ea2b7ca516745bfeafc49904b496089), "c3", 1'b1, 0, 1'b1,
              to_rm(128'h00112233445566778899aabbccddeeff));
    for (int i = 0; i < 2; i++) run_block(rnd128(), $sformatf("r14_%0d", i), 1'b0, 0, 1'b0, '0);
    back_to_back("b2b14");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
